// File: rtl/unidad_acceso_memoria.sv
// MEM-stage load/store unit: byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW mapped onto word accesses of memoria_datos.
// Latency: word store 1 cycle; load and sub-word store (read-modify-write) 2 cycles; o_stall is high only in the first cycle.
// Backpressure: o_stall freezes upstream stages; LOAD_STORE_SUBWORD_EN enables byte/half access, otherwise every access is a word.
module unidad_acceso_memoria #(
    parameter int RAM_WIDTH     = 32,
    parameter int CANT_BIT_ADDR = 11
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_valid,
    input  logic                     i_mem_read,
    input  logic                     i_mem_write,
    input  logic [1:0]               i_size,
    input  logic                     i_unsigned,
    input  logic [31:0]              i_addr,
    input  logic [RAM_WIDTH-1:0]     i_data_store,
    input  logic [RAM_WIDTH-1:0]     i_mem_data,
    output logic [CANT_BIT_ADDR-1:0] o_mem_addr,
    output logic [RAM_WIDTH-1:0]     o_mem_data,
    output logic                     o_mem_ena,
    output logic                     o_mem_wea,
    output logic                     o_stall,
    output logic [RAM_WIDTH-1:0]     o_data_load,
    output logic                     o_load_valid,
    output logic                     o_misaligned,
    output logic                     o_error
);
    typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_WRITE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t                   state, next_state;
    logic                     err_q, err_set, latch_en;
    logic                     req, misaligned;
    logic [1:0]               size_eff;
    logic [CANT_BIT_ADDR-1:0] lat_word;
    logic                     unused_bits;

`ifdef LOAD_STORE_SUBWORD_EN
    logic [1:0]           lat_low, lat_size;
    logic                 lat_uns;
    logic [15:0]          lat_data;
    logic [7:0]           sel_byte;
    logic [15:0]          sel_half;
    logic [RAM_WIDTH-1:0] ext_load, merged;

    assign unused_bits = ^i_addr[31:CANT_BIT_ADDR+2];
    assign size_eff    = (i_size == 2'b11) ? SZ_WORD : i_size;
`else
    assign unused_bits = ^{i_addr[31:CANT_BIT_ADDR+2], i_size, i_unsigned};
    assign size_eff    = SZ_WORD;
`endif

    // A simultaneous read+write is a store; the read is dropped.
    assign req        = i_valid & (i_mem_read | i_mem_write);
    assign misaligned = req & (((size_eff == SZ_HALF) & i_addr[0]) |
                               ((size_eff == SZ_WORD) & (i_addr[1:0] != 2'b00)));
    assign o_error    = err_q & ~i_reset;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            err_q <= 1'b0;
        end else begin
            state <= next_state;
            if (err_set)
                err_q <= 1'b1;
            if (latch_en) begin
                lat_word <= i_addr[CANT_BIT_ADDR+1:2];
`ifdef LOAD_STORE_SUBWORD_EN
                lat_low  <= i_addr[1:0];
                lat_size <= size_eff;
                lat_uns  <= i_unsigned;
                lat_data <= i_data_store[15:0];
`endif
            end
        end
    end

`ifdef LOAD_STORE_SUBWORD_EN
    // Little-endian lanes: byte k at [8k+7:8k], half h at [16h+15:16h].
    always_comb begin
        sel_byte = i_mem_data[{lat_low, 3'b000} +: 8];
        sel_half = i_mem_data[{lat_low[1], 4'b0000} +: 16];
        case (lat_size)
            SZ_BYTE: ext_load = {{(RAM_WIDTH-8){~lat_uns & sel_byte[7]}}, sel_byte};
            SZ_HALF: ext_load = {{(RAM_WIDTH-16){~lat_uns & sel_half[15]}}, sel_half};
            default: ext_load = i_mem_data;
        endcase
        merged = i_mem_data;
        if (lat_size == SZ_BYTE)
            merged[{lat_low, 3'b000} +: 8] = lat_data[7:0];
        else
            merged[{lat_low[1], 4'b0000} +: 16] = lat_data;
    end
`endif

    always_comb begin
        next_state   = state;
        o_mem_addr   = i_addr[CANT_BIT_ADDR+1:2];
        o_mem_data   = '0;
        o_mem_ena    = 1'b0;
        o_mem_wea    = 1'b0;
        o_stall      = 1'b0;
        o_data_load  = '0;
        o_load_valid = 1'b0;
        o_misaligned = 1'b0;
        err_set      = 1'b0;
        latch_en     = 1'b0;
        case (state)
            IDLE: begin
                if (misaligned) begin
                    o_misaligned = 1'b1;
                    err_set      = 1'b1;
                end else if (req && i_mem_write && size_eff == SZ_WORD) begin
                    o_mem_ena  = 1'b1;
                    o_mem_wea  = 1'b1;
                    o_mem_data = i_data_store;
                end else if (req) begin
                    // Load, or the read half of a sub-word read-modify-write.
                    o_mem_ena = 1'b1;
                    o_stall   = 1'b1;
                    latch_en  = 1'b1;
`ifdef LOAD_STORE_SUBWORD_EN
                    next_state = i_mem_write ? RMW_WRITE : LOAD_WAIT;
`else
                    next_state = LOAD_WAIT;
`endif
                end
            end
            LOAD_WAIT: begin
                o_mem_addr   = lat_word;
                o_load_valid = 1'b1;
`ifdef LOAD_STORE_SUBWORD_EN
                o_data_load  = ext_load;
`else
                o_data_load  = i_mem_data;
`endif
                next_state   = IDLE;
            end
`ifdef LOAD_STORE_SUBWORD_EN
            RMW_WRITE: begin
                o_mem_addr = lat_word;
                o_mem_ena  = 1'b1;
                o_mem_wea  = 1'b1;
                o_mem_data = merged;
                next_state = IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
        // Reset also kills a pending RMW write in the same cycle.
        if (i_reset) begin
            o_mem_ena    = 1'b0;
            o_mem_wea    = 1'b0;
            o_stall      = 1'b0;
            o_load_valid = 1'b0;
            o_misaligned = 1'b0;
            err_set      = 1'b0;
            latch_en     = 1'b0;
        end
    end
endmodule

// File: tb/tb_unidad_acceso_memoria.sv
// Bench for unidad_acceso_memoria: directed test-plan sequence plus random traffic against a transaction-level model.
module tb_unidad_acceso_memoria;
    logic        i_clk = 1'b0;
    logic        i_reset, i_valid, i_mem_read, i_mem_write, i_unsigned;
    logic [1:0]  i_size;
    logic [31:0] i_addr, i_data_store, mem_q;
    logic [10:0] o_mem_addr;
    logic [31:0] o_mem_data, o_data_load;
    logic        o_mem_ena, o_mem_wea, o_stall, o_load_valid, o_misaligned, o_error;

    always #5 i_clk = ~i_clk;

    unidad_acceso_memoria #(.RAM_WIDTH(32), .CANT_BIT_ADDR(11)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_mem_read(i_mem_read),
        .i_mem_write(i_mem_write), .i_size(i_size), .i_unsigned(i_unsigned), .i_addr(i_addr),
        .i_data_store(i_data_store), .i_mem_data(mem_q), .o_mem_addr(o_mem_addr),
        .o_mem_data(o_mem_data), .o_mem_ena(o_mem_ena), .o_mem_wea(o_mem_wea), .o_stall(o_stall),
        .o_data_load(o_data_load), .o_load_valid(o_load_valid), .o_misaligned(o_misaligned),
        .o_error(o_error)
    );

    // memoria_datos stand-in: 1-cycle read latency, read-first.
    logic [31:0] ram [0:2047];
    always @(posedge i_clk) begin
        if (o_mem_ena) begin
            if (o_mem_wea)
                ram[o_mem_addr] <= o_mem_data;
            mem_q <= ram[o_mem_addr];
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: golden word memory plus at most one pending two-cycle operation.
    logic [31:0] gold [0:2047];
    int          pend_kind;   // 0 none, 1 load result due, 2 merged write due
    logic [31:0] pend_addr, pend_data;
    logic [1:0]  pend_size;
    logic        pend_uns;
    logic        m_err;

    function automatic int widx(input logic [31:0] a);
        return int'(a[12:2]);
    endfunction

    function automatic logic [1:0] eff_size(input logic [1:0] s);
`ifdef LOAD_STORE_SUBWORD_EN
        return (s == 2'd3) ? 2'd2 : s;
`else
        return 2'd2;
`endif
    endfunction

    function automatic bit misal(input logic [1:0] a, input logic [1:0] sz);
        return (sz == 2'd1 && a[0]) || (sz == 2'd2 && a != 2'd0);
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                            input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        int sh;
        if (sz == 2'd0) begin
            sh = 8 * int'(a);
            v = (w >> sh) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            sh = 16 * int'(a[1]);
            v = (w >> sh) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] a,
                                          input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] m;
        int sh;
        if (sz == 2'd0) begin
            sh = 8 * int'(a);
            m = 32'hFF << sh;
        end else begin
            sh = 16 * int'(a[1]);
            m = 32'hFFFF << sh;
        end
        return (w & ~m) | ((d << sh) & m);
    endfunction

    // Model advance on each clock edge, using the inputs held during the cycle.
    always @(posedge i_clk) begin : model_step
        logic [1:0] sz;
        sz = eff_size(i_size);
        if (i_reset) begin
            pend_kind = 0;
            m_err = 1'b0;
        end else if (pend_kind == 1) begin
            pend_kind = 0;
        end else if (pend_kind == 2) begin
            gold[widx(pend_addr)] = merge(gold[widx(pend_addr)], pend_addr[1:0], pend_size, pend_data);
            pend_kind = 0;
        end else if (i_valid && (i_mem_read || i_mem_write)) begin
            if (misal(i_addr[1:0], sz)) begin
                m_err = 1'b1;
            end else if (i_mem_write && sz == 2'd2) begin
                gold[widx(i_addr)] = i_data_store;
            end else begin
                pend_kind = i_mem_write ? 2 : 1;
                pend_addr = i_addr;
                pend_size = sz;
                pend_uns  = i_unsigned;
                pend_data = i_data_store;
            end
        end
    end

    // Compare process: every cycle, mid-period.
    always @(negedge i_clk) begin : compare
        logic        e_ena, e_wea, e_stall, e_lv, e_mis, e_err, chk_addr, quiet;
        logic [1:0]  sz;
        logic [31:0] e_dat, e_load;
        int          e_addr;
        e_ena = 0; e_wea = 0; e_stall = 0; e_lv = 0; e_mis = 0; chk_addr = 0;
        e_dat = '0; e_load = '0;
        e_addr = widx(i_addr);
        e_err = m_err && !i_reset;
        quiet = (pend_kind == 0) && !i_valid && !i_reset;
        sz = eff_size(i_size);
        if (!i_reset) begin
            if (pend_kind == 1) begin
                e_lv = 1;
                e_load = extract(gold[widx(pend_addr)], pend_addr[1:0], pend_size, pend_uns);
            end else if (pend_kind == 2) begin
                e_ena = 1; e_wea = 1; chk_addr = 1;
                e_addr = widx(pend_addr);
                e_dat = merge(gold[widx(pend_addr)], pend_addr[1:0], pend_size, pend_data);
            end else begin
                chk_addr = 1;
                if (i_valid && (i_mem_read || i_mem_write)) begin
                    if (misal(i_addr[1:0], sz)) begin
                        e_mis = 1;
                    end else if (i_mem_write && sz == 2'd2) begin
                        e_ena = 1; e_wea = 1; e_dat = i_data_store;
                    end else begin
                        e_ena = 1; e_stall = 1;
                    end
                end
            end
        end
        check("mem_ena", 32'(o_mem_ena), 32'(e_ena));
        check("mem_wea", 32'(o_mem_wea), 32'(e_wea));
        check("stall", 32'(o_stall), 32'(e_stall));
        check("load_valid", 32'(o_load_valid), 32'(e_lv));
        check("misaligned", 32'(o_misaligned), 32'(e_mis));
        check("error", 32'(o_error), 32'(e_err));
        if (chk_addr) check("mem_addr", 32'(o_mem_addr), 32'(e_addr));
        if (e_wea || quiet) check("mem_data", o_mem_data, e_dat);
        if (e_lv || quiet) check("data_load", o_data_load, e_load);
    end

    task automatic drive(input bit rst, input bit v, input bit r, input bit w, input logic [1:0] sz,
                         input bit uns, input logic [31:0] a, input logic [31:0] d);
        @(posedge i_clk);
        #1;
        i_reset = rst; i_valid = v; i_mem_read = r; i_mem_write = w;
        i_size = sz; i_unsigned = uns; i_addr = a; i_data_store = d;
    endtask

    task automatic idle(input bit rst);
        drive(rst, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input bit uns,
                           input logic [31:0] exp, input string name);
        drive(1'b0, 1'b1, 1'b1, 1'b0, sz, uns, a, 32'h0);
        @(negedge i_clk);
        check({name, "_stall"}, 32'(o_stall), 32'd1);
        idle(1'b0);
        @(negedge i_clk);
        check({name, "_valid"}, 32'(o_load_valid), 32'd1);
        check(name, o_data_load, exp);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            ram[i] = '0;
            gold[i] = '0;
        end
        mem_q = '0; pend_kind = 0; m_err = 1'b0;
        pend_addr = '0; pend_data = '0; pend_size = '0; pend_uns = 1'b0;
        i_reset = 1'b1; i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
        i_size = 2'd0; i_unsigned = 1'b0; i_addr = '0; i_data_store = '0;

        check("pin_lb", extract(32'hDEADAAEF, 2'd2, 2'd0, 1'b0), 32'hFFFFFFAD);
        check("pin_lhu", extract(32'hDEADAAEF, 2'd2, 2'd1, 1'b1), 32'h0000DEAD);
        check("pin_sb", merge(32'hDEADBEEF, 2'd1, 2'd0, 32'h000000AA), 32'hDEADAAEF);

        idle(1'b1);
        idle(1'b1);
        @(negedge i_clk);
        check("rst_stall", 32'(o_stall), 32'd0);
        check("rst_ena", 32'(o_mem_ena), 32'd0);
        idle(1'b0);
        @(negedge i_clk);
        check("idle_error", 32'(o_error), 32'd0);

        drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        @(negedge i_clk);
        check("sw_addr", 32'(o_mem_addr), 32'd4);
        check("sw_wea", 32'(o_mem_wea), 32'd1);
        check("sw_data", o_mem_data, 32'hDEADBEEF);
        check("sw_stall", 32'(o_stall), 32'd0);

        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        @(negedge i_clk);
        check("lw_t_wea", 32'(o_mem_wea), 32'd0);
        idle(1'b0);
        @(negedge i_clk);
        check("lw_t1_stall", 32'(o_stall), 32'd0);
        check("lw_data", o_data_load, 32'hDEADBEEF);

`ifdef LOAD_STORE_SUBWORD_EN
        drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA);
        @(negedge i_clk);
        check("sb_t_stall", 32'(o_stall), 32'd1);
        check("sb_t_addr", 32'(o_mem_addr), 32'd4);
        idle(1'b0);
        @(negedge i_clk);
        check("sb_t1_wea", 32'(o_mem_wea), 32'd1);
        check("sb_t1_data", o_mem_data, 32'hDEADAAEF);
        do_load(32'h10, 2'd2, 1'b0, 32'hDEADAAEF, "lw_after_sb");
        do_load(32'h12, 2'd0, 1'b0, 32'hFFFFFFAD, "lb");
        do_load(32'h12, 2'd0, 1'b1, 32'h000000AD, "lbu");
        do_load(32'h12, 2'd1, 1'b0, 32'hFFFFDEAD, "lh");
        do_load(32'h12, 2'd1, 1'b1, 32'h0000DEAD, "lhu");

        drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 32'h10, 32'h00001234);
        idle(1'b1);
        @(negedge i_clk);
        check("sh_rst_wea", 32'(o_mem_wea), 32'd0);
        idle(1'b0);
        do_load(32'h10, 2'd2, 1'b0, 32'hDEADAAEF, "lw_after_abort");
`endif

        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h13, 32'h0);
        @(negedge i_clk);
        check("mis_pulse", 32'(o_misaligned), 32'd1);
        check("mis_ena", 32'(o_mem_ena), 32'd0);
        check("mis_stall", 32'(o_stall), 32'd0);
        idle(1'b0);
        @(negedge i_clk);
        check("mis_one_cycle", 32'(o_misaligned), 32'd0);
        check("err_sticky1", 32'(o_error), 32'd1);
        idle(1'b0);
        @(negedge i_clk);
        check("err_sticky2", 32'(o_error), 32'd1);
        idle(1'b1);
        @(negedge i_clk);
        check("err_rst", 32'(o_error), 32'd0);
        idle(1'b0);

        // Random traffic over 16 words; random upper address bits exercise wrap-around.
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] a;
            a = $urandom;
            a[12:6] = 7'd0;
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
        end
        for (int n = 0; n < 4; n++) idle(1'b0);
        @(negedge i_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/unidad_acceso_memoria.md
# unidad_acceso_memoria

MEM-stage load/store unit of the MIPS pipeline, sitting between the EX/MEM latch and `memoria_datos`. It converts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word accesses on the data memory. Sub-word loads are extracted and sign- or zero-extended. Sub-word stores are done as read-modify-write. The pipeline is stalled for the extra cycle that loads and sub-word stores need.

## Interface
Parameters:
- `RAM_WIDTH`, 32, data word width; fixed at 32 for byte-lane logic.
- `CANT_BIT_ADDR`, 11, width of the word address driven to `memoria_datos.i_addr`.

Ports:
- `i_clk`  in  1  pipeline clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  MEM-stage request present.
- `i_mem_read`  in  1  load request.
- `i_mem_write`  in  1  store request.
- `i_size`  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- `i_unsigned`  in  1  selects zero-extension on loads (LBU/LHU).
- `i_addr`  in  32  byte address (ALU result).
- `i_data_store`  in  32  store data, right-aligned.
- `i_mem_data`  in  32  `memoria_datos.o_data`.
- `o_mem_addr`  out  CANT_BIT_ADDR  word address = `i_addr[CANT_BIT_ADDR+1:2]`.
- `o_mem_data`  out  32  word written to memory.
- `o_mem_ena`  out  1  memory enable.
- `o_mem_wea`  out  1  memory write enable.
- `o_stall`  out  1  freeze upstream stages and the EX/MEM latch.
- `o_data_load`  out  32  extended load result.
- `o_load_valid`  out  1  `o_data_load` is valid this cycle.
- `o_misaligned`  out  1  current request is misaligned; one-cycle pulse.
- `o_error`  out  1  sticky misalignment flag.

## Operation
- States: IDLE, LOAD_WAIT, RMW_WRITE.
- Request decode in IDLE:
  - A request is `i_valid` with `i_mem_read` or `i_mem_write` set.
  - If both are set, the write wins and the read is ignored.
- Alignment check:
  - Half with `i_addr[0]=1` is misaligned.
  - Word with `i_addr[1:0]!=0` is misaligned.
  - On misalignment: `o_misaligned=1`, `o_error` sets, no memory access, no stall, state stays IDLE.
- Word store:
  - `o_mem_ena=1`, `o_mem_wea=1`, `o_mem_data=i_data_store` in the same cycle.
  - State stays IDLE.
- Load:
  - Cycle T: `o_mem_ena=1`, `o_stall=1`. Address, size and `i_unsigned` are latched. Next state is LOAD_WAIT.
  - LOAD_WAIT: the lane is selected from `i_mem_data` using the latched `addr[1:0]` and extended into `o_data_load`. `o_load_valid=1`, `o_stall=0`. Next state is IDLE.
- Sub-word store:
  - Cycle T: read of the word, `o_stall=1`. Address, size and data are latched. Next state is RMW_WRITE.
  - RMW_WRITE: `o_mem_data` is `i_mem_data` with the target lane replaced. `o_mem_wea=1`, `o_stall=0`. Next state is IDLE.
- Byte lanes are little-endian:
  - Byte k occupies bits [8k+7:8k], k=`addr[1:0]`.
  - Half h occupies bits [16h+15:16h], h=`addr[1]`.
- Extension: sign-extend when `i_unsigned=0`; zero-extend otherwise. Word loads pass through unchanged.
- Address bits above `CANT_BIT_ADDR+1` are ignored, so addresses wrap modulo the memory size.
- New requests are ignored in LOAD_WAIT and RMW_WRITE. The latched copy is used.

## Timing
- Word store: 1 cycle, no stall.
- Load and sub-word store: 2 cycles, `o_stall` high only in the first cycle.
- The memory read latency of 1 cycle (LOW_LATENCY) is fixed.
- Back-to-back requests: a new request is accepted in the cycle after LOAD_WAIT or RMW_WRITE.
- Reset:
  - While `i_reset=1`: state returns to IDLE, `o_error=0`, and `o_mem_ena`, `o_mem_wea`, `o_stall`, `o_load_valid`, `o_misaligned` are forced to 0.
  - Reset during RMW_WRITE aborts the write; the memory word is unchanged.
- With `i_valid=0` in IDLE, all outputs are 0 except `o_mem_addr`, which follows `i_addr`.

## Configuration
- Macro: `LOAD_STORE_SUBWORD_EN`.
- Defined: full byte/half/word behaviour as above.
- Undefined:
  - `i_size` and `i_unsigned` are ignored; every access is a word access.
  - RMW_WRITE is not built; stores are always single-cycle.
  - Only the word alignment check remains.

## Test plan
- Reset, then SW 0xDEADBEEF at 0x10 → `o_mem_addr=4`, `o_mem_wea=1`, `o_mem_data=0xDEADBEEF`, `o_stall=0`.
- LW 0x10 → cycle T `o_stall=1`, `o_mem_wea=0`; T+1 `o_data_load=0xDEADBEEF`, `o_load_valid=1`.
- SB 0xAA at 0x11 → T: read word 4, `o_stall=1`; T+1: write 0xDEADAAEF. A following LW 0x10 returns 0xDEADAAEF.
- Sub-word loads from word 0xDEADAAEF:
  - LB 0x12 → 0xFFFFFFAD; LBU 0x12 → 0x000000AD.
  - LH 0x12 → 0xFFFFDEAD; LHU 0x12 → 0x0000DEAD.
- LW 0x13 → `o_misaligned=1` for one cycle, `o_mem_ena=0`, `o_stall=0`, `o_error` stays 1 until reset.
- SH 0x1234 at 0x10 with `i_reset` asserted during RMW_WRITE → `o_mem_wea=0`, word 4 unchanged, state IDLE; next LW 0x10 returns the old value.
